// File: rtl/extend_unit_pkg.sv
// Shared definitions for the immediate extend unit.
//   XLEN      - data path width
//   immsrc_e  - immediate format select encoding (I/S/B/J)
package extend_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_e;

endpackage

// File: rtl/extend_unit_imm_decode.sv
// imm_decode: purely combinational immediate decoder.
//   instr  [31:7] - instruction bits (opcode bits [6:0] not needed)
//   immsrc [1:0]  - format select (see immsrc_e)
//   imm    [31:0] - sign-extended immediate; sign always instr[31]
module imm_decode
    import extend_unit_pkg::*;
(
    input  logic [31:7]     instr,
    input  logic [1:0]      immsrc,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (immsrc_e'(immsrc))
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            // branch/jump offsets are halfword aligned, so bit 0 is fixed at 0
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/extend_unit.sv
// extend_unit: immediate decoder with an optional output register.
//   REG_OUT   - 1: registered outputs (1-cycle latency); 0: combinational,
//               clk/reset unused
//   clk       - rising-edge clock
//   reset     - asynchronous active-high reset
//   in_valid  - qualifies instr/immsrc for capture
//   instr     - instruction bits [31:7]
//   immsrc    - immediate format select
//   immext    - sign-extended immediate
//   out_valid - immext holds a result captured from a valid input
module extend_unit
    import extend_unit_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:7]     instr,
    input  logic [1:0]      immsrc,
    output logic [XLEN-1:0] immext,
    output logic            out_valid
);

    logic [XLEN-1:0] imm;

    imm_decode u_imm_decode (
        .instr  (instr),
        .immsrc (immsrc),
        .imm    (imm)
    );

    generate
        if (REG_OUT) begin : g_reg
            // immext only loads on valid input so it holds across idle cycles;
            // out_valid tracks whether the last edge actually captured.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    immext    <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        immext <= imm;
                    end
                end
            end
        end else begin : g_comb
            always_comb begin
                immext    = imm;
                out_valid = in_valid;
            end
        end
    endgenerate

endmodule

// File: tb/tb_extend_unit.sv
module tb_extend_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:7] instr;
    logic [1:0]  immsrc;
    logic [31:0] immext_r, immext_c;
    logic        out_valid_r, out_valid_c;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    logic [31:0] sbq[$];
    logic [31:0] last_exp;

    extend_unit #(.REG_OUT(1'b1)) dut_reg (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
        .immsrc(immsrc), .immext(immext_r), .out_valid(out_valid_r)
    );

    extend_unit #(.REG_OUT(1'b0)) dut_comb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
        .immsrc(immsrc), .immext(immext_c), .out_valid(out_valid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference immediate built from the full 32-bit instruction word.
    function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] r;
        case (s)
            2'b00: r = {{20{w[31]}}, w[31:20]};
            2'b01: r = {{20{w[31]}}, w[31:25], w[11:7]};
            2'b10: r = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            default: r = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Drive one cycle: check the combinational instance before the edge,
    // the registered instance #1 after it through the scoreboard.
    task automatic drive(input logic v, input logic [31:0] w, input logic [1:0] s,
                         input logic [31:0] exp, input string name);
        logic [31:0] e;
        in_valid = v;
        instr    = w[31:7];
        immsrc   = s;
        #1;
        check({name, "_comb_imm"}, immext_c, exp);
        check({name, "_comb_vld"}, {31'b0, out_valid_c}, {31'b0, v});
        if (v) sbq.push_back(exp);
        @(posedge clk);
        #1;
        check({name, "_reg_vld"}, {31'b0, out_valid_r}, {31'b0, v});
        if (v) begin
            if (sbq.size() == 0) begin
                check({name, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                check({name, "_reg_imm"}, immext_r, e);
                last_exp = e;
            end
        end else begin
            check({name, "_reg_hold"}, immext_r, last_exp);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        logic [1:0]  src;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] w;
        logic [1:0]  s;
        logic        v;

        tbl[0] = '{32'h8CDEFAB7, 2'b00, 32'hFFFFF8CD};
        tbl[1] = '{32'h8CDEFAB7, 2'b01, 32'hFFFFF8D5};
        tbl[2] = '{32'h8CDEFAB7, 2'b10, 32'hFFFFF8D4};
        tbl[3] = '{32'h8CDEFAB7, 2'b11, 32'hFFFEF8CC};
        tbl[4] = '{32'h7FF00000, 2'b00, 32'h000007FF};
        tbl[5] = '{32'h80000000, 2'b11, 32'hFFF00000};
        tbl[6] = '{32'h80000000, 2'b10, 32'hFFFFF000};
        tbl[7] = '{32'h00000F80, 2'b01, 32'h0000001F};

        // Reset held with valid, arbitrary inputs: registered outputs stay clear.
        reset    = 1'b1;
        in_valid = 1'b1;
        instr    = 25'h1ABCDEF;
        immsrc   = 2'b11;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_imm", immext_r, 32'h0);
            check("rst_vld", {31'b0, out_valid_r}, 32'h0);
            instr  = 25'($urandom);
            immsrc = 2'($urandom);
            @(negedge clk);
            check("rst_imm_neg", immext_r, 32'h0);
            check("rst_vld_neg", {31'b0, out_valid_r}, 32'h0);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        last_exp = 32'h0;

        // Back-to-back table vectors; first capture on first edge after release.
        for (int unsigned i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].word, tbl[i].src, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // One valid, then three idle cycles: value holds, out_valid drops.
        drive(1'b1, 32'h7FF00000, 2'b00, 32'h000007FF, "hold_load");
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1'b0, 32'h8CDEFAB7, 2'b01, 32'hFFFFF8D5, $sformatf("hold%0d", i));
        end

        // immsrc change with instr fixed.
        drive(1'b1, 32'h8CDEFAB7, 2'b00, 32'hFFFFF8CD, "src_a");
        drive(1'b1, 32'h8CDEFAB7, 2'b11, 32'hFFFEF8CC, "src_b");

        // Asynchronous reset mid-stream, between edges.
        drive(1'b1, 32'h8CDEFAB7, 2'b10, 32'hFFFFF8D4, "pre_arst");
        in_valid = 1'b1;
        instr    = 25'h1234567;
        #3;
        reset = 1'b1;
        #1;
        check("arst_imm", immext_r, 32'h0);
        check("arst_vld", {31'b0, out_valid_r}, 32'h0);
        sbq.delete();
        @(posedge clk);
        #1;
        check("arst_hold_imm", immext_r, 32'h0);
        reset    = 1'b0;
        last_exp = 32'h0;
        drive(1'b0, 32'h7FF00000, 2'b00, 32'h000007FF, "post_arst_idle");
        drive(1'b1, 32'h80000000, 2'b10, 32'hFFFFF000, "post_arst_cap");

        // Random stream with mixed valid.
        for (int unsigned i = 0; i < 24; i++) begin
            w = $urandom;
            s = 2'($urandom);
            v = 1'($urandom);
            drive(v, w, s, ref_imm(w, s), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/extend_unit.md
EXTEND_UNIT -- requirements
Module: extend_unit

Interface
REQ-001 Parameter REG_OUT, default 1: 1 = registered outputs (1-cycle latency); 0 = combinational outputs with clk/reset unused.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  qualifies instr/immsrc for capture.
REQ-005 instr  input  25  instruction bits [31:7], indexed 31 down to 7; bits [6:0] are not ports.
REQ-006 immsrc  input  2  immediate format select.
REQ-007 immext  output  32  sign-extended immediate.
REQ-008 out_valid  output  1  immext holds a result captured from a valid input.

Function
REQ-009 immsrc=00 (I-type) SHALL give {20 x instr[31], instr[31:20]}.
REQ-010 immsrc=01 (S-type) SHALL give {20 x instr[31], instr[31:25], instr[11:7]}.
REQ-011 immsrc=10 (B-type) SHALL give {19 x instr[31], instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-012 immsrc=11 (J-type) SHALL give {11 x instr[31], instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-013 Decode SHALL be pure combinational; every immsrc value is defined; no X propagation for known inputs.
REQ-014 Sign bit SHALL always be instr[31]; B and J results SHALL have bit0 = 0.
REQ-015 REG_OUT=1: on the rising edge with in_valid=1, immext SHALL load the decoded value and out_valid SHALL be 1 on the next cycle.
REQ-016 REG_OUT=1: on the rising edge with in_valid=0, immext SHALL hold its previous value and out_valid SHALL go to 0.
REQ-017 Back-to-back valid inputs SHALL produce back-to-back results; throughput is one per cycle.
REQ-018 Changing immsrc with instr fixed SHALL change the result one cycle later (REG_OUT=1) or immediately (REG_OUT=0).
REQ-019 REG_OUT=0: out_valid SHALL equal in_valid and immext SHALL equal the decode of the current inputs.

Reset
REQ-020 While reset=1, immext SHALL be 32'h0000_0000 and out_valid SHALL be 0, independent of clk.
REQ-021 Reset asserted mid-stream SHALL discard any in-flight result.
REQ-022 The first valid capture after reset SHALL occur on the first rising edge with reset=0 and in_valid=1.

Structure
REQ-023 A shared package SHALL define the immsrc encoding enum (IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11) and the data width constant XLEN=32.
REQ-024 The decode SHALL be one combinational sub-module, imm_decode (instr, immsrc -> imm); extend_unit SHALL wrap it with the optional output register.

Verification
REQ-025 Apply reset=1 with in_valid=1 and arbitrary inputs -> immext=0 and out_valid=0 throughout reset.
REQ-026 Apply instr = bits[31:7] of 32'h8CDEFAB7 with immsrc 00, 01, 10, 11 on successive valid cycles -> immext = FFFFF8CD, FFFFF8D5, FFFFF8D4, FFFEF8CC, each one cycle after its input.
REQ-027 Apply instr = bits[31:7] of 32'h7FF00000 with immsrc=00 -> immext=000007FF (positive, no sign fill).
REQ-028 Apply one valid cycle, then in_valid=0 for 3 cycles -> immext holds its value and out_valid=0 after the first invalid edge.
REQ-029 Assert reset asynchronously between clock edges during a valid stream -> outputs clear immediately; no stale result after release.
REQ-030 With REG_OUT=0, repeat the REQ-026 stimulus -> same values with zero latency.
